// File: rtl/apb_master_nslv.sv
// APB master bridging a valid/ready command port onto NSLV APB slaves.
// Slave select comes from the top address bits; optional ACCESS-phase timeout.
module apb_master_nslv #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  input  logic [DATA_W/8-1:0]    cmd_strb,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [NSLV-1:0]        PSEL,
  output logic                   PENABLE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic                   PWRITE,
  output logic [DATA_W-1:0]      PWDATA,
  output logic [DATA_W/8-1:0]    PSTRB,
  input  logic [NSLV*DATA_W-1:0] PRDATA,
  input  logic [NSLV-1:0]        PREADY,
  input  logic [NSLV-1:0]        PSLVERR
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t        state, state_n;
  logic [SW-1:0] idx, idx_in;
  logic [CW-1:0] wcnt;
  logic          hs, done, abort, sel_rdy;

  generate
    if (NSLV == 1) begin : g_one
      assign idx_in = '0;
    end else begin : g_many
      assign idx_in = cmd_addr[ADDR_W-1 -: SW];
    end
  endgenerate

  assign hs      = cmd_valid && cmd_ready;
  assign sel_rdy = PREADY[idx];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_n;
  end

  // A ready slave wins over the timeout on the same edge.
  always_comb begin
    state_n = state;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE:   if (hs) state_n = SETUP;
      SETUP:  state_n = ACCESS;
      ACCESS: begin
        if (sel_rdy) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (TIMEOUT > 0 && wcnt == CW'(TIMEOUT)) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      idx       <= '0;
      wcnt      <= '0;
    end else begin
      cmd_ready <= (state_n == IDLE);
      rsp_valid <= done || abort;
      if (hs) begin
        idx    <= idx_in;
        PSEL   <= NSLV'(1) << idx_in;
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_write ? cmd_wdata : '0;
        PSTRB  <= cmd_write ? cmd_strb  : '0;
        wcnt   <= '0;
      end
      if (state == SETUP) PENABLE <= 1'b1;
      if (state == ACCESS && !sel_rdy) wcnt <= wcnt + CW'(1);
      if (done || abort) begin
        PSEL      <= '0;
        PENABLE   <= 1'b0;
        rsp_err   <= abort || PSLVERR[idx];
        rsp_rdata <= (done && !PWRITE) ? PRDATA[idx*DATA_W +: DATA_W] : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Bench for apb_master_nslv: per-transfer cycle-schedule model plus directed vectors
// with hand-computed expectations.
module tb_apb_master_nslv;

  localparam int TIMEOUT = 16;

  logic         PCLK = 1'b0;
  logic         PRESET = 1'b0;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr, cmd_wdata;
  logic [3:0]   cmd_strb;
  logic         rsp_valid, rsp_err;
  logic [31:0]  rsp_rdata;
  logic [3:0]   PSEL;
  logic         PENABLE, PWRITE;
  logic [31:0]  PADDR, PWDATA;
  logic [3:0]   PSTRB;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY, PSLVERR;

  apb_master_nslv #(.ADDR_W(32), .DATA_W(32), .NSLV(4), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s bound expired at %0t", nm, $time);
  endtask

  // Slave responders: wait sl_wait ACCESS cycles, then ready. Unselected slaves
  // and not-yet-ready selected slaves drive junk that must be ignored.
  int          sl_wait [4];
  logic        sl_err  [4];
  logic [31:0] sl_data [4];
  int          acc_cnt = 0;

  always @(posedge PCLK) acc_cnt <= (PENABLE && PSEL != 4'b0) ? acc_cnt + 1 : 0;

  always_comb begin
    logic rdy;
    PREADY  = '1;
    PSLVERR = '1;
    PRDATA  = '0;
    for (int i = 0; i < 4; i++) begin
      rdy = 1'b0;
      if (PSEL[i]) begin
        rdy              = PENABLE && (acc_cnt >= sl_wait[i]);
        PREADY[i]        = rdy;
        PSLVERR[i]       = rdy ? sl_err[i] : 1'b1;
        PRDATA[i*32+:32] = rdy ? sl_data[i] : (32'hFFFF_0000 | 32'(i));
      end else begin
        PRDATA[i*32+:32] = 32'hBAD0_0000 | 32'(i);
      end
    end
  end

  // Model: on each accepted command, lay out the whole expected cycle schedule.
  typedef struct {
    logic [3:0]  psel;
    logic        pen;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        rv;
    logic        rdy;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t cur = '{default: '0};
  exp_t q[$];

  initial forever begin
    exp_t e;
    int w, a;
    logic ab;
    logic [1:0] ix;
    logic [3:0] one;
    @(posedge PCLK or posedge PRESET);
    if (PRESET) begin
      cur = '{default: '0};
      q.delete();
    end else begin
      if (cur.rdy && cmd_valid) begin
        one = 4'b0001;
        ix  = cmd_addr[31:30];
        w   = sl_wait[ix];
        ab  = (TIMEOUT > 0) && (w > TIMEOUT);
        a   = ab ? TIMEOUT + 1 : w + 1;
        e        = cur;
        e.psel   = one << ix;
        e.pen    = 1'b0;
        e.paddr  = cmd_addr;
        e.pwrite = cmd_write;
        e.pwdata = cmd_write ? cmd_wdata : 32'h0;
        e.pstrb  = cmd_write ? cmd_strb : 4'h0;
        e.rv     = 1'b0;
        e.rdy    = 1'b0;
        q.delete();
        q.push_back(e);
        e.pen = 1'b1;
        for (int k = 0; k < a; k++) q.push_back(e);
        e.psel  = 4'b0;
        e.pen   = 1'b0;
        e.rv    = 1'b1;
        e.rdy   = 1'b1;
        e.rdata = (ab || cmd_write) ? 32'h0 : sl_data[ix];
        e.err   = ab || sl_err[ix];
        q.push_back(e);
      end
      if (q.size() > 0) cur = q.pop_front();
      else begin
        cur.psel = 4'b0;
        cur.pen  = 1'b0;
        cur.rv   = 1'b0;
        cur.rdy  = 1'b1;
      end
    end
  end

  initial begin
    @(negedge PCLK);
    forever begin
      @(negedge PCLK);
      chk("cmd_ready", cmd_ready, cur.rdy);
      chk("PSEL", PSEL, cur.psel);
      chk("PENABLE", PENABLE, cur.pen);
      chk("rsp_valid", rsp_valid, cur.rv);
      chk("rsp_rdata", rsp_rdata, cur.rdata);
      chk("rsp_err", rsp_err, cur.err);
      if (cur.psel != 4'b0) begin
        chk("PADDR", PADDR, cur.paddr);
        chk("PWRITE", PWRITE, cur.pwrite);
        chk("PWDATA", PWDATA, cur.pwdata);
        chk("PSTRB", PSTRB, cur.pstrb);
      end
    end
  end

  // Transfer observation results
  int          o_nacc, o_lat, o_pulses;
  logic [3:0]  o_psel, o_pstrb, o_psel_rsp;
  logic [31:0] o_rdata;
  logic        o_err;

  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    logic r;
    bit ok;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge PCLK);
      r = cmd_ready;
      @(posedge PCLK);
      if (r) ok = 1;
    end
    #1 cmd_valid = 1'b0;
    if (!ok) fail_now("send_handshake");
  endtask

  task automatic mon();
    bit fin;
    o_nacc = 0; o_lat = 0; o_pulses = 0;
    o_psel = 'x; o_pstrb = 'x; o_psel_rsp = 'x; o_rdata = 'x; o_err = 1'bx;
    fin = 0;
    for (int k = 1; k <= 60 && !fin; k++) begin
      @(negedge PCLK);
      if (PSEL != 4'b0 && !PENABLE) begin
        o_psel  = PSEL;
        o_pstrb = PSTRB;
      end
      if (PENABLE) o_nacc++;
      if (rsp_valid) begin
        o_lat      = k;
        o_rdata    = rsp_rdata;
        o_err      = rsp_err;
        o_psel_rsp = PSEL;
        o_pulses++;
        fin = 1;
      end
    end
    if (!fin) fail_now("mon_response");
    @(negedge PCLK);
    if (rsp_valid) o_pulses++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic r;
    bit ok;
    logic [6:0] pat;
    int pulses;
    for (int i = 0; i < 4; i++) begin
      sl_wait[i] = 0;
      sl_err[i]  = 1'b0;
      sl_data[i] = 32'h0101_0101 * (i + 1);
    end
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_psel", PSEL, 0);
    #1 PRESET = 1'b0;
    @(posedge PCLK); #1;

    // zero-wait write to slave 1
    send(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    mon();
    chk("t1_psel", o_psel, 4'b0010);
    chk("t1_nacc", o_nacc, 1);
    chk("t1_lat", o_lat, 3);
    chk("t1_err", o_err, 0);
    chk("t1_rdata", o_rdata, 0);

    // read slave 3 with two wait states; write fields must be zeroed
    sl_wait[3] = 2;
    sl_data[3] = 32'h1234_5678;
    send(1'b0, 32'hC000_0004, 32'h5555_AAAA, 4'hF);
    mon();
    chk("t2_psel", o_psel, 4'b1000);
    chk("t2_nacc", o_nacc, 3);
    chk("t2_pstrb", o_pstrb, 0);
    chk("t2_rdata", o_rdata, 32'h1234_5678);
    chk("t2_err", o_err, 0);

    // read slave 2 with error
    sl_err[2]  = 1'b1;
    sl_data[2] = 32'hAAAA_5555;
    send(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    mon();
    chk("t3_err", o_err, 1);
    chk("t3_pulses", o_pulses, 1);
    chk("t3_rdata", o_rdata, 32'hAAAA_5555);
    repeat (3) @(negedge PCLK);
    chk("t3_hold_rdata", rsp_rdata, 32'hAAAA_5555);
    chk("t3_hold_err", rsp_err, 1);

    // timeout on slave 0
    sl_wait[0] = 255;
    send(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    mon();
    chk("t4_nacc", o_nacc, 17);
    chk("t4_lat", o_lat, 19);
    chk("t4_err", o_err, 1);
    chk("t4_rdata", o_rdata, 0);
    chk("t4_psel_rsp", o_psel_rsp, 0);

    // ready arrives exactly at the timeout count: completes normally
    sl_wait[0] = 16;
    send(1'b1, 32'h0000_000C, 32'h0BAD_F00D, 4'h3);
    mon();
    chk("t5_nacc", o_nacc, 17);
    chk("t5_err", o_err, 0);

    // reset during ACCESS
    sl_wait[0] = 255;
    send(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge PCLK);
      ok = PENABLE;
    end
    if (!ok) fail_now("t6_access");
    #2 PRESET = 1'b1;
    #1;
    chk("t6_psel", PSEL, 0);
    chk("t6_penable", PENABLE, 0);
    chk("t6_cmd_ready", cmd_ready, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge PCLK);
      if (rsp_valid) pulses++;
    end
    chk("t6_no_rsp", pulses, 0);
    chk("t6_ready_after", cmd_ready, 1);

    // normal write after reset
    sl_err[2] = 1'b0;
    send(1'b1, 32'h8000_0040, 32'hCAFE_0001, 4'hF);
    mon();
    chk("t7_psel", o_psel, 4'b0100);
    chk("t7_nacc", o_nacc, 1);
    chk("t7_lat", o_lat, 3);
    chk("t7_err", o_err, 0);

    // back-to-back writes with cmd_valid held
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0100;
    cmd_wdata = 32'h1111_1111; cmd_strb = 4'hF;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge PCLK);
      r = cmd_ready;
      @(posedge PCLK);
      if (r) ok = 1;
    end
    if (!ok) fail_now("t8_handshake");
    #1 cmd_addr = 32'h4000_0104;
    cmd_wdata = 32'h2222_2222;
    pat = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge PCLK);
      pat[6-k] = |PSEL;
      if (k == 2) begin
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
      end
    end
    chk("t8_psel_pattern", pat, 7'b1101100);
    repeat (3) @(negedge PCLK);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master_nslv.md
APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values 8/16/32/64.
REQ-003 SHALL have parameter NSLV, default 4, slave count; legal values 1/2/4/8/16.
REQ-004 SHALL have parameter TIMEOUT, default 16, max ACCESS wait cycles; 0 disables timeout.
REQ-005 SHALL have ports (name direction width meaning):
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  slave error or timeout.
- PSEL  out  NSLV  one-hot slave select.
- PENABLE  out  1  APB access phase.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  DATA_W/8  APB strobes.
- PRDATA  in  NSLV*DATA_W  read data; slave i at bits [i*DATA_W +: DATA_W].
- PREADY  in  NSLV  per-slave ready.
- PSLVERR  in  NSLV  per-slave error.

Function
REQ-006 SHALL implement FSM IDLE, SETUP, ACCESS; all APB and rsp outputs registered.
REQ-007 SHALL drive cmd_ready=1 only in IDLE; handshake = cmd_valid && cmd_ready at rising PCLK.
REQ-008 On handshake SHALL latch addr/wdata/strb/write, go to SETUP next cycle.
REQ-009 SETUP: PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB valid; idx = PADDR[ADDR_W-1 -: log2(NSLV)], idx=0 when NSLV=1.
REQ-010 Reads SHALL drive PSTRB=0 and PWDATA=0.
REQ-011 SETUP SHALL last exactly one cycle, then ACCESS with PENABLE=1.
REQ-012 PADDR, PWRITE, PWDATA, PSTRB, PSEL SHALL be stable from SETUP through last ACCESS cycle.
REQ-013 ACCESS SHALL complete on the first edge with PREADY[idx]=1; PREADY/PSLVERR/PRDATA of unselected slaves ignored.
REQ-014 On completion SHALL capture rsp_rdata = PRDATA slice idx (reads) or 0 (writes), rsp_err = PSLVERR[idx].
REQ-015 PSLVERR SHALL be sampled only with PREADY[idx]=1 in ACCESS.
REQ-016 Wait counter SHALL reset on SETUP entry, increment per ACCESS cycle with PREADY[idx]=0.
REQ-017 TIMEOUT>0 and counter==TIMEOUT with PREADY[idx]=0 SHALL abort: rsp_err=1, rsp_rdata=0, PSEL/PENABLE deasserted next cycle.
REQ-018 Cycle after completion/abort SHALL be IDLE with rsp_valid=1 for exactly one cycle, PSEL=0, PENABLE=0, cmd_ready=1.
REQ-019 Command accepted in rsp_valid cycle SHALL enter SETUP next cycle; zero-wait throughput one transfer per 3 cycles.
REQ-020 cmd_valid while cmd_ready=0 SHALL be ignored; requester holds.
REQ-021 rsp_rdata and rsp_err SHALL hold until next completion.

Reset
REQ-022 PRESET=1 SHALL immediately force IDLE, counter 0, all outputs 0 (cmd_ready 0 while PRESET high).
REQ-023 Reset mid-transfer SHALL drop transfer with no rsp_valid; cmd_ready=1 first edge after PRESET falls.

Verification
REQ-024 Write 0x4000_0010, data 0xDEAD_BEEF, strb 0xF, slave 1 PREADY=1 -> PSEL=0b0010 SETUP 1 cycle, PENABLE 1 cycle, rsp_valid on 3rd cycle, rsp_err=0.
REQ-025 Read 0xC000_0004, slave 3 returns 0x1234_5678 after 2 wait cycles -> ACCESS 3 cycles, rsp_rdata=0x1234_5678, PSTRB=0.
REQ-026 Read slave 2 with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_valid one pulse.
REQ-027 Slave 0 PREADY held 0, TIMEOUT=16 -> abort after 16 wait cycles, rsp_err=1, rsp_rdata=0, PSEL=0 next cycle.
REQ-028 PRESET asserted in ACCESS -> outputs 0 same cycle, no rsp_valid; new command after release completes normally.
REQ-029 Two back-to-back writes, cmd_valid held -> second accepted in first's rsp_valid cycle; PSEL gaps exactly one cycle.
